// File: rtl/mac_pkg.sv
// Shared definitions for the N x N result streamout: widths, streamer states, header layout.
// The header feature is enabled by defining MAC_STREAMOUT_HDR_EN.
package mac_pkg;

    localparam int W_DEF      = 16;
    localparam int HDR_FCNT_W = 8;

`ifdef MAC_STREAMOUT_HDR_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif

    typedef enum logic {
        STREAM_IDLE = 1'b0,
        STREAM_RUN  = 1'b1
    } stream_state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int hdr_ovf_bit(input int w);
        return w - 1;
    endfunction

    function automatic int hdr_cm_bit(input int w);
        return w - 2;
    endfunction

    function automatic int hdr_cnt_w(input int w);
        return w - 2;
    endfunction

endpackage

// File: rtl/mac_stream_ser.sv
// Tile serializer: holds one stream buffer and emits it as a gapless word stream.
// With MAC_STREAMOUT_HDR_EN each frame starts with a header word carrying a frame count.
module mac_stream_ser
    import mac_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [N*N*W-1:0] tile_i,
    input  logic             col_major_i,
`ifdef MAC_STREAMOUT_HDR_EN
    input  logic             ovf_i,
`endif
    output logic             valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic [W-1:0]     data_o
);

    localparam int NN = N * N;
    localparam int FL = NN + HDR_WORDS;
    localparam int CW = clog2_min1(FL);
    localparam logic [CW-1:0] CNT_LAST = CW'(FL - 1);

    stream_state_e   state_q;
    logic [NN*W-1:0] buf_q;
    logic            cm_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            valid_q;
    logic            first_q;
    logic [W-1:0]    data_q;

    // Buffer is packed row-major; column-major order transposes the word index.
    function automatic logic [W-1:0] pick(input logic [NN*W-1:0] t, input int k, input logic cm);
        int e;
        e = cm ? ((k % N) * N + k / N) : k;
        return t[e*W +: W];
    endfunction

`ifdef MAC_STREAMOUT_HDR_EN
    localparam int OVF_BIT = hdr_ovf_bit(W);
    localparam int CM_BIT  = hdr_cm_bit(W);
    localparam int CNTW    = hdr_cnt_w(W);

    logic [HDR_FCNT_W-1:0] fcnt_q;

    function automatic logic [W-1:0] hdr_word(input logic ovf, input logic cm,
                                              input logic [HDR_FCNT_W-1:0] fc);
        logic [W-1:0] h;
        h            = '0;
        h[CNTW-1:0]  = CNTW'(fc);
        h[OVF_BIT]   = ovf;
        h[CM_BIT]    = cm;
        return h;
    endfunction
`endif

    assign last_o = (state_q == STREAM_RUN) && (cnt_q == CNT_LAST);
    assign cnt_d  = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STREAM_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            data_q  <= '0;
`ifdef MAC_STREAMOUT_HDR_EN
            fcnt_q  <= '0;
`endif
        end else if (load_i) begin
            state_q <= STREAM_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            buf_q   <= tile_i;
            cm_q    <= col_major_i;
`ifdef MAC_STREAMOUT_HDR_EN
            data_q  <= hdr_word(ovf_i, col_major_i, fcnt_q);
            fcnt_q  <= fcnt_q + 1'b1;
`else
            data_q  <= pick(tile_i, 0, col_major_i);
`endif
        end else if ((state_q == STREAM_RUN) && !last_o) begin
            cnt_q   <= cnt_d;
            first_q <= 1'b0;
            data_q  <= pick(buf_q, int'(cnt_d) - HDR_WORDS, cm_q);
        end else begin
            state_q <= STREAM_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            data_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign first_o = first_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mac_streamout_nxn.sv
// Collects an N x N result tile one anti-diagonal per beat and streams it out gaplessly,
// with a one-tile pending slot and sticky overflow. MAC_STREAMOUT_HDR_EN adds frame headers.
module mac_streamout_nxn
    import mac_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             res_valid_i,
    input  logic [clog2_min1(2*N-1)-1:0]     res_diag_i,
    input  logic [N*W-1:0]                   res_data_i,
    input  logic                             col_major_i,
    output logic                             valid_o,
    output logic                             first_o,
    output logic [W-1:0]                     data_o,
    output logic                             overflow_o
);

    localparam int NN = N * N;
    localparam int DW = clog2_min1(2 * N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(2 * N - 2);

    logic [NN*W-1:0] gather_q;
    logic [NN*W-1:0] gather_d;
    logic            pending_q;
    logic            drop_q;
    logic            overflow_q;
    logic            in_range;
    logic            start_beat;
    logic            last_beat;
    logic            wr_en;
    logic            tile_done;
    logic            load;
    logic            ser_last;

    assign in_range   = res_valid_i && (res_diag_i <= D_LAST);
    assign start_beat = in_range && (res_diag_i == '0);
    assign last_beat  = in_range && (res_diag_i == D_LAST);
    // A tile that started while one was pending is dropped until its last diagonal passes.
    assign wr_en      = in_range && !pending_q && (!drop_q || start_beat);
    assign tile_done  = wr_en && (res_diag_i == D_LAST);
    assign load       = (tile_done && (!valid_o || ser_last)) || (pending_q && ser_last);

    always_comb begin
        gather_d = gather_q;
        if (wr_en) begin
            for (int r = 0; r < N; r++) begin
                if ((int'(res_diag_i) >= r) && (int'(res_diag_i) - r < N))
                    gather_d[(r * N + int'(res_diag_i) - r) * W +: W] = res_data_i[r * W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        gather_q <= gather_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= 1'b0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (load && pending_q)
                pending_q <= 1'b0;
            else if (tile_done && !load)
                pending_q <= 1'b1;

            if (start_beat && pending_q) begin
                drop_q     <= 1'b1;
                overflow_q <= 1'b1;
            end else if (start_beat || last_beat) begin
                drop_q <= 1'b0;
            end
        end
    end

    mac_stream_ser #(
        .W (W),
        .N (N)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .tile_i      (gather_d),
        .col_major_i (col_major_i),
`ifdef MAC_STREAMOUT_HDR_EN
        .ovf_i       (overflow_q),
`endif
        .valid_o     (valid_o),
        .first_o     (first_o),
        .last_o      (ser_last),
        .data_o      (data_o)
    );

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mac_streamout_nxn.sv
// Bench for mac_streamout_nxn: an N=2/W=16 and an N=4/W=8 instance checked against a
// matrix-level model of the expected word stream (header words when MAC_STREAMOUT_HDR_EN).
module tb_mac_streamout_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic v2, cm2, vo2, fo2, ov2;
    logic [1:0]  d2;
    logic [31:0] x2;
    logic [15:0] do2;
    logic v4, cm4, vo4, fo4, ov4;
    logic [2:0]  d4;
    logic [31:0] x4;
    logic [7:0]  do4;

    mac_streamout_nxn #(.W(16), .N(2)) u_dut2 (
        .clk(clk), .rst(rst), .res_valid_i(v2), .res_diag_i(d2), .res_data_i(x2),
        .col_major_i(cm2), .valid_o(vo2), .first_o(fo2), .data_o(do2), .overflow_o(ov2));

    mac_streamout_nxn #(.W(8), .N(4)) u_dut4 (
        .clk(clk), .rst(rst), .res_valid_i(v4), .res_diag_i(d4), .res_data_i(x4),
        .col_major_i(cm4), .valid_o(vo4), .first_o(fo4), .data_o(do4), .overflow_o(ov4));

    int n_chk = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;
    logic [16:0] q2[$];
    logic [16:0] q4[$];
    logic [16:0] e2, e4;
    int fc2 = 0, fc4 = 0;
    bit eovf2 = 1'b0, eovf4 = 1'b0;
    logic [15:0] m[4][4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected frame straight from the tile matrix and the stream order.
    task automatic push_frame(input int sel, input int n, input bit cm);
        int w;
        bit first;
        logic [15:0] word;
        w = sel ? 8 : 16;
        first = 1'b1;
`ifdef MAC_STREAMOUT_HDR_EN
        begin
            int h;
            h = ((sel ? eovf4 : eovf2) ? (1 << (w - 1)) : 0) + (cm ? (1 << (w - 2)) : 0)
                + (((sel ? fc4 : fc2) % 256) % (1 << (w - 2)));
            word = h[15:0];
            if (sel) begin q4.push_back({first, word}); fc4++; end
            else     begin q2.push_back({first, word}); fc2++; end
            first = 1'b0;
        end
`endif
        for (int k = 0; k < n * n; k++) begin
            word = cm ? m[k % n][k / n] : m[k / n][k % n];
            if (sel) q4.push_back({first, word});
            else     q2.push_back({first, word});
            first = 1'b0;
        end
    endtask

    task automatic drive(input int sel, input bit v, input int d, input logic [31:0] bus, input bit cm);
        if (sel) begin v4 = v; d4 = d[2:0]; x4 = bus; cm4 = cm; end
        else     begin v2 = v; d2 = d[1:0]; x2 = bus; cm2 = cm; end
        @(posedge clk); #1;
        if (sel) v4 = 1'b0; else v2 = 1'b0;
    endtask

    // Present the tile in m as 2n-1 diagonal beats; lanes outside the tile carry junk.
    task automatic send_tile(input int sel, input int n, input bit cm, input bit noise);
        logic [31:0] bus;
        for (int d = 0; d <= 2 * n - 2; d++) begin
            if (noise && $urandom_range(0, 3) == 0)
                drive(sel, 1'b1, 2 * n - 1, $urandom, cm);
            if (noise && $urandom_range(0, 3) == 0)
                drive(sel, 1'b0, $urandom_range(0, 2 * n - 2), $urandom, cm);
            bus = $urandom;
            for (int r = 0; r < n; r++) begin
                if (d - r >= 0 && d - r < n) begin
                    if (sel) bus[r*8 +: 8]   = m[r][d-r][7:0];
                    else     bus[r*16 +: 16] = m[r][d-r];
                end
            end
            drive(sel, 1'b1, d, bus, cm);
        end
    endtask

    task automatic drain(input int sel);
        int i = 0;
        while (((sel ? q4.size() : q2.size()) != 0) && i < 200) begin
            @(posedge clk);
            i++;
        end
        check(sel ? "drain4" : "drain2", sel ? q4.size() : q2.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rand_tile(input int sel);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = sel ? {8'h00, 8'($urandom)} : 16'($urandom);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (vo2) begin
                if (q2.size() == 0) check("u2_extra_word", vo2, 0);
                else begin
                    e2 = q2.pop_front();
                    check("u2_data", do2, e2[15:0]);
                    check("u2_first", fo2, e2[16]);
                end
            end else begin
                check("u2_idle_data", do2, 0);
                if (q2.size() != 0) check("u2_gap", vo2, 1);
            end
            if (vo4) begin
                if (q4.size() == 0) check("u4_extra_word", vo4, 0);
                else begin
                    e4 = q4.pop_front();
                    check("u4_data", do4, e4[7:0]);
                    check("u4_first", fo4, e4[16]);
                end
            end else begin
                check("u4_idle_data", do4, 0);
                if (q4.size() != 0) check("u4_gap", vo4, 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        v2 = 0; d2 = 0; x2 = 0; cm2 = 0;
        v4 = 0; d4 = 0; x4 = 0; cm4 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", vo2, 0);
        check("rst_first", fo2, 0);
        check("rst_data", do2, 0);
        check("rst_ovf", ov2, 0);
        check("rst_valid4", vo4, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        m[0][0] = 16'h0011; m[0][1] = 16'h0012;
        m[1][0] = 16'h0021; m[1][1] = 16'h0022;
        send_tile(0, 2, 1'b0, 1'b0);
        push_frame(0, 2, 1'b0);
        drain(0);
        send_tile(0, 2, 1'b1, 1'b0);
        push_frame(0, 2, 1'b1);
        drain(0);

        // Second tile completes mid-frame and must follow without a gap.
        rand_tile(0);
        send_tile(0, 2, 1'b0, 1'b0);
        push_frame(0, 2, 1'b0);
        rand_tile(0);
        send_tile(0, 2, 1'b1, 1'b0);
        push_frame(0, 2, 1'b1);
        drain(0);
        check("b2b_ovf", ov2, 0);

        // Third tile starts while the second is still pending and is lost.
        rand_tile(0);
        send_tile(0, 2, 1'b0, 1'b0);
        push_frame(0, 2, 1'b0);
        rand_tile(0);
        send_tile(0, 2, 1'b0, 1'b0);
        push_frame(0, 2, 1'b0);
        rand_tile(0);
        send_tile(0, 2, 1'b0, 1'b0);
        eovf2 = 1'b1;
        check("ovf_set", ov2, 1);
        drain(0);
        rand_tile(0);
        send_tile(0, 2, 1'b1, 1'b0);
        push_frame(0, 2, 1'b1);
        drain(0);
        check("ovf_sticky", ov2, 1);

        // Reset while word 1 is on the output.
        rand_tile(0);
        send_tile(0, 2, 1'b0, 1'b0);
        push_frame(0, 2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        q2.delete();
        fc2 = 0; fc4 = 0; eovf2 = 1'b0; eovf4 = 1'b0;
        check("rst_abort_valid", vo2, 0);
        check("rst_abort_ovf", ov2, 0);
        rst = 1'b0;
        rand_tile(0);
        send_tile(0, 2, 1'b1, 1'b1);
        push_frame(0, 2, 1'b1);
        drain(0);
        check("post_rst_ovf", ov2, 0);

        for (int t = 0; t < 8; t++) begin
            rand_tile(1);
            send_tile(1, 4, t[0], 1'b1);
            push_frame(1, 4, t[0]);
            drain(1);
        end
        check("u4_ovf", ov4, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
